shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 reqN_valid  input  1  request N (N=0,1) valid.
REQ-005 reqN_ready  output  1  request N accepted this cycle when high with reqN_valid.
REQ-006 reqN_valA  input  32  operand to shift.
REQ-007 reqN_valB  input  32  shift amount; only [4:0] significant.
REQ-008 reqN_sftmode  input  2  00 rotate right, 01 shift left, 10 shift right, 11 rotate left.
REQ-009 reqN_signed  input  1  arithmetic fill for shift right.
REQ-010 sh_valA, sh_valB, sh_sftmode, sh_signed  output  32/32/2/1  operands driven to the shared combinational shifter_rotator.
REQ-011 sh_result, sh_pushed  input  32/1  shifter outputs, valid in the same cycle as the driven operands.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  response consumer ready.
REQ-014 rsp_id  output  1  requester index of the response.
REQ-015 rsp_result, rsp_pushed  output  32/1  captured shifter result and last bit shifted out.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done_cnt  output  16  count of completed responses.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC and RESP, with exactly one operation in flight.
REQ-019 IDLE: reqN_ready SHALL equal the arbiter grant for N; both readys SHALL be low in EXEC and RESP.
REQ-020 Arbitration SHALL be round-robin: with a single valid, that requester is granted; with both valid, the requester not granted last is granted.
REQ-021 The last_grant register SHALL update only on an accepted request.
REQ-022 On accept (valid&&ready), the block SHALL register valA, {27'b0, valB[4:0]}, sftmode, signed and id, then go to EXEC.
REQ-023 Registered operands SHALL drive sh_* continuously.
REQ-024 sh_valB bits [31:5] SHALL always be 0.
REQ-025 EXEC (one cycle): the block SHALL capture sh_result, sh_pushed and id into the response registers and go to RESP.
REQ-026 RESP: rsp_valid SHALL be 1 and response fields stable until rsp_valid&&rsp_ready.
REQ-027 On that handshake, the block SHALL go to IDLE and increment done_cnt modulo 2^16 (0xFFFF -> 0x0000).
REQ-028 Latency SHALL be: accept in cycle N, rsp_valid high in cycle N+2.
REQ-029 With rsp_ready held high, the next accept SHALL occur in cycle N+3, giving a throughput of 1 op per 3 cycles.
REQ-030 A valid request is not required to be held after acceptance; a request not accepted is held by the requester.
REQ-031 A shift amount of 0 SHALL return valA unchanged with rsp_pushed=0.
REQ-032 rsp_valid SHALL never be high in IDLE or EXEC.

Reset
REQ-033 reset_n low SHALL force asynchronously: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_pushed=0, done_cnt=0, busy=0, both readys=0, and all operand registers 0.
REQ-034 On reset, last_grant SHALL be set to 1, so requester 0 wins the first tie.
REQ-035 Reset asserted mid-operation SHALL discard the in-flight operation; no response SHALL be produced for it after release.
REQ-036 Arbitration SHALL resume in the cycle after reset_n rises.

Verification
REQ-037 Shift left: req0 sftmode=01, valA=0x80000001, valB=1 -> two cycles later rsp_valid=1, rsp_id=0, rsp_result=0x00000002, rsp_pushed=1.
REQ-038 Arithmetic right: req1 sftmode=10, signed=1, valA=0x80000000, valB=0x00000024 (amount 4) -> rsp_result=0xF8000000, rsp_pushed=0, sh_valB=0x00000004.
REQ-039 Rotates: sftmode=11, valA=0x12345678, valB=8 -> 0x34567812; then sftmode=00, valA=0x000000F1, valB=4 -> 0x1000000F.
REQ-040 Round-robin: both valid continuously from reset -> grant order 0,1,0,1; rsp_ready low for 5 cycles in RESP -> response fields stable, no new accept.
REQ-041 Reset during EXEC -> rsp_valid stays 0 after release and done_cnt=0; a done_cnt preset to 0xFFFF via 65535 ops followed by one more op -> done_cnt=0x0000.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared combinational shifter.
// One operation in flight: accept, execute for one cycle, then hold the response.
module shift_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_valA,
  input  logic [31:0] req0_valB,
  input  logic [1:0]  req0_sftmode,
  input  logic        req0_signed,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_valA,
  input  logic [31:0] req1_valB,
  input  logic [1:0]  req1_sftmode,
  input  logic        req1_signed,
  output logic [31:0] sh_valA,
  output logic [31:0] sh_valB,
  output logic [1:0]  sh_sftmode,
  output logic        sh_signed,
  input  logic [31:0] sh_result,
  input  logic        sh_pushed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_pushed,
  output logic        busy,
  output logic [15:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        last_grant;
  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic        hs;
  logic [31:0] op_a;
  logic [4:0]  op_b;
  logic [1:0]  op_mode;
  logic        op_signed;
  logic        op_id;
  logic        unused_hi;

  assign unused_hi = ^{req0_valB[31:5], req1_valB[31:5]};

  // On a tie the requester that did not win last time takes the grant.
  assign gnt0 = req0_valid & (~req1_valid | last_grant);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);

  assign accept = req0_ready | req1_ready;
  assign hs     = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = reset_n & gnt0;
        req1_ready = reset_n & gnt1;
        busy       = 1'b0;
      end
      EXEC:    rsp_valid = 1'b0;
      RESP:    rsp_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_mode    <= '0;
      op_signed  <= 1'b0;
      op_id      <= 1'b0;
    end else if (accept) begin
      last_grant <= gnt1;
      op_id      <= gnt1;
      unique case (1'b1)
        gnt0: begin
          op_a      <= req0_valA;
          op_b      <= req0_valB[4:0];
          op_mode   <= req0_sftmode;
          op_signed <= req0_signed;
        end
        gnt1: begin
          op_a      <= req1_valA;
          op_b      <= req1_valB[4:0];
          op_mode   <= req1_sftmode;
          op_signed <= req1_signed;
        end
        default: op_id <= gnt1;
      endcase
    end
  end

  assign sh_valA    = op_a;
  assign sh_valB    = {27'b0, op_b};
  assign sh_sftmode = op_mode;
  assign sh_signed  = op_signed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_pushed <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= op_id;
      rsp_result <= sh_result;
      rsp_pushed <= sh_pushed;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  done_cnt <= '0;
    else if (hs)   done_cnt <= done_cnt + 16'd1;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural shifter_rotator
// attached to the sh_* port.
module tb_shift_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_valA, req0_valB, req1_valA, req1_valB;
  logic [1:0]  req0_sftmode, req1_sftmode;
  logic        req0_signed, req1_signed;
  logic [31:0] sh_valA, sh_valB, sh_result;
  logic [1:0]  sh_sftmode;
  logic        sh_signed, sh_pushed;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_pushed, busy;
  logic [31:0] rsp_result;
  logic [15:0] done_cnt;

  int checks = 0;
  int fails  = 0;
  int exp_done = 0;
  int k;

  shift_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_valA(req0_valA), .req0_valB(req0_valB),
    .req0_sftmode(req0_sftmode), .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_valA(req1_valA), .req1_valB(req1_valB),
    .req1_sftmode(req1_sftmode), .req1_signed(req1_signed),
    .sh_valA(sh_valA), .sh_valB(sh_valB),
    .sh_sftmode(sh_sftmode), .sh_signed(sh_signed),
    .sh_result(sh_result), .sh_pushed(sh_pushed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_pushed(rsp_pushed), .busy(busy), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared combinational shifter_rotator.
  always_comb begin
    sh_result = sh_valA;
    sh_pushed = 1'b0;
    k = int'(sh_valB[4:0]);
    if (k != 0) begin
      case (sh_sftmode)
        2'b00: begin
          sh_result = (sh_valA >> k) | (sh_valA << (32 - k));
          sh_pushed = sh_valA[k-1];
        end
        2'b01: begin
          sh_result = sh_valA << k;
          sh_pushed = sh_valA[32-k];
        end
        2'b10: begin
          if (sh_signed) sh_result = 32'($signed(sh_valA) >>> k);
          else           sh_result = sh_valA >> k;
          sh_pushed = sh_valA[k-1];
        end
        default: begin
          sh_result = (sh_valA << k) | (sh_valA >> (32 - k));
          sh_pushed = sh_valA[32-k];
        end
      endcase
    end
  end

  task automatic issue(input bit id, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] m,
                       input logic s, output bit acc);
    @(negedge clk);
    if (!id) begin
      req0_valid = 1; req0_valA = a; req0_valB = b;
      req0_sftmode = m; req0_signed = s;
    end else begin
      req1_valid = 1; req1_valA = a; req1_valB = b;
      req1_sftmode = m; req1_signed = s;
    end
    #1 acc = id ? req1_ready : req0_ready;
    @(posedge clk);
    #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_reset;
    reset_n = 0; rsp_ready = 1;
    req0_valid = 1; req1_valid = 0;
    req0_valA = 32'hFFFF_FFFF; req0_valB = 32'hFFFF_FFFF;
    req0_sftmode = 2'b11; req0_signed = 1;
    req1_valA = 0; req1_valB = 0; req1_sftmode = 0; req1_signed = 0;
    #12;
    checks++;
    if (req0_ready !== 0 || req1_ready !== 0 || busy !== 0 ||
        rsp_valid !== 0) begin
      fails++;
      $display("FAIL reset_ctrl: rdy0=%b rdy1=%b busy=%b rv=%b, need all 0",
               req0_ready, req1_ready, busy, rsp_valid);
    end
    checks++;
    if (rsp_id !== 0 || rsp_result !== 0 || rsp_pushed !== 0 ||
        done_cnt !== 0) begin
      fails++;
      $display("FAIL reset_rsp: id=%b res=%h p=%b cnt=%h, need 0",
               rsp_id, rsp_result, rsp_pushed, done_cnt);
    end
    checks++;
    if (sh_valA !== 0 || sh_valB !== 0 || sh_sftmode !== 0 ||
        sh_signed !== 0) begin
      fails++;
      $display("FAIL reset_ops: a=%h b=%h m=%b s=%b, need 0",
               sh_valA, sh_valB, sh_sftmode, sh_signed);
    end
    @(negedge clk);
    req0_valid = 0;
    reset_n = 1;
  endtask

  task automatic test_shift_left;
    bit acc;
    issue(0, 32'h8000_0001, 32'd1, 2'b01, 0, acc);
    checks++;
    if (acc !== 1) begin
      fails++;
      $display("FAIL sl_accept: ready0=%b, need 1", acc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1 || rsp_valid !== 0 || sh_valA !== 32'h8000_0001 ||
        sh_valB !== 32'd1) begin
      fails++;
      $display("FAIL sl_exec: busy=%b rv=%b a=%h b=%h, need 1 0 80000001 1",
               busy, rsp_valid, sh_valA, sh_valB);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1 || rsp_id !== 0 || rsp_result !== 32'h2 ||
        rsp_pushed !== 1) begin
      fails++;
      $display("FAIL sl_rsp: rv=%b id=%b res=%h p=%b, need 1 0 00000002 1",
               rsp_valid, rsp_id, rsp_result, rsp_pushed);
    end
    exp_done++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 0 || busy !== 0 || done_cnt !== 16'(exp_done)) begin
      fails++;
      $display("FAIL sl_done: rv=%b busy=%b cnt=%0d, need 0 0 %0d",
               rsp_valid, busy, done_cnt, exp_done);
    end
  endtask

  task automatic test_arith_right;
    bit acc;
    issue(1, 32'h8000_0000, 32'h24, 2'b10, 1, acc);
    checks++;
    if (acc !== 1) begin
      fails++;
      $display("FAIL sra_accept: ready1=%b, need 1", acc);
    end
    @(negedge clk);
    checks++;
    if (sh_valB !== 32'h4 || sh_signed !== 1 || sh_sftmode !== 2'b10) begin
      fails++;
      $display("FAIL sra_ops: b=%h s=%b m=%b, need 00000004 1 10",
               sh_valB, sh_signed, sh_sftmode);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1 || rsp_id !== 1 || rsp_result !== 32'hF800_0000 ||
        rsp_pushed !== 0) begin
      fails++;
      $display("FAIL sra_rsp: rv=%b id=%b res=%h p=%b, need 1 1 f8000000 0",
               rsp_valid, rsp_id, rsp_result, rsp_pushed);
    end
    exp_done++;
    @(negedge clk);
  endtask

  task automatic test_rotates;
    bit acc;
    issue(0, 32'h1234_5678, 32'd8, 2'b11, 0, acc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1 || rsp_result !== 32'h3456_7812 || rsp_pushed !== 0) begin
      fails++;
      $display("FAIL rotl: rv=%b res=%h p=%b, need 1 34567812 0",
               rsp_valid, rsp_result, rsp_pushed);
    end
    exp_done++;
    issue(1, 32'h0000_00F1, 32'd4, 2'b00, 0, acc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1 || rsp_id !== 1 || rsp_result !== 32'h1000_000F) begin
      fails++;
      $display("FAIL rotr: rv=%b id=%b res=%h, need 1 1 1000000f",
               rsp_valid, rsp_id, rsp_result);
    end
    exp_done++;
    // amount 0 (bit 5 set only) must pass valA through with no pushed bit
    issue(0, 32'hDEAD_BEEF, 32'h20, 2'b01, 0, acc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_result !== 32'hDEAD_BEEF || rsp_pushed !== 0) begin
      fails++;
      $display("FAIL zero_amt: res=%h p=%b, need deadbeef 0",
               rsp_result, rsp_pushed);
    end
    exp_done++;
    @(negedge clk);
    checks++;
    if (done_cnt !== 16'(exp_done)) begin
      fails++;
      $display("FAIL cnt_after_rot: cnt=%0d, need %0d", done_cnt, exp_done);
    end
  endtask

  task automatic test_round_robin;
    bit g[4];
    int n;
    int seen;
    logic [31:0] cap_res;
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    exp_done = 0;
    rsp_ready = 1;
    req0_valA = 32'h11; req0_valB = 0; req0_sftmode = 2'b01; req0_signed = 0;
    req1_valA = 32'h22; req1_valB = 0; req1_sftmode = 2'b01; req1_signed = 0;
    req0_valid = 1; req1_valid = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) begin
        fails++;
        checks++;
        $display("FAIL rr_both: both readys high, need one");
      end
      if (req0_ready) begin g[n] = 0; n++; end
      else if (req1_ready) begin g[n] = 1; n++; end
      if (n == 4) rsp_ready = 0;
      else @(negedge clk);
    end
    checks++;
    if (n != 4 || g[0] !== 0 || g[1] !== 1 || g[2] !== 0 || g[3] !== 1) begin
      fails++;
      $display("FAIL rr_order: got %0d grants %b%b%b%b, need 0101",
               n, g[0], g[1], g[2], g[3]);
    end
    exp_done = 3;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1 if (rsp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL rr_wait: rsp_valid=0 after 10 cycles, need 1");
    end
    cap_res = rsp_result;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1 || rsp_id !== 1 || rsp_result !== 32'h22 ||
          rsp_result !== cap_res || req0_ready !== 0 || req1_ready !== 0) begin
        fails++;
        $display("FAIL rr_stall%0d: rv=%b id=%b res=%h r0=%b r1=%b, need 1 1 22 0 0",
                 c, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    exp_done++;
    checks++;
    if (rsp_valid !== 0 || done_cnt !== 16'(exp_done)) begin
      fails++;
      $display("FAIL rr_release: rv=%b cnt=%0d, need 0 %0d",
               rsp_valid, done_cnt, exp_done);
    end
  endtask

  task automatic test_reset_mid;
    bit acc;
    issue(0, 32'h0000_0003, 32'd1, 2'b01, 0, acc);
    @(negedge clk);
    checks++;
    if (busy !== 1) begin
      fails++;
      $display("FAIL mid_exec: busy=%b, need 1", busy);
    end
    reset_n = 0;
    #1;
    checks++;
    if (rsp_valid !== 0 || busy !== 0 || done_cnt !== 0 ||
        rsp_result !== 0) begin
      fails++;
      $display("FAIL mid_reset: rv=%b busy=%b cnt=%0d res=%h, need 0 0 0 0",
               rsp_valid, busy, done_cnt, rsp_result);
    end
    @(negedge clk);
    reset_n = 1;
    exp_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 0 || done_cnt !== 0) begin
        fails++;
        $display("FAIL mid_after%0d: rv=%b cnt=%0d, need 0 0",
                 c, rsp_valid, done_cnt);
      end
    end
  endtask

  task automatic test_wrap;
    bit acc;
    @(negedge clk);
    force dut.done_cnt = 16'hFFFF;
    #1 release dut.done_cnt;
    #1;
    checks++;
    if (done_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_preset: cnt=%h, need ffff", done_cnt);
    end
    issue(1, 32'h0000_0001, 32'd31, 2'b01, 0, acc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1 || rsp_result !== 32'h8000_0000 ||
        done_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_rsp: rv=%b res=%h cnt=%h, need 1 80000000 ffff",
               rsp_valid, rsp_result, done_cnt);
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_cnt: cnt=%h, need 0000", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_arith_right();
    test_rotates();
    test_round_robin();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
